sauria_demo_ctrl: RTL

SAURIA_DEMO_CTRL -- requirements
Module: sauria_demo_ctrl

---
 rtl/sauria_demo_pkg.sv | 34 +++
 rtl/sauria_demo_chan.sv | 73 +++++++
 rtl/sauria_demo_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/sauria_demo_pkg.sv
// Shared definitions for the SAURIA demo controller: register map, channel
// state encoding and the Cheshire external-port sizing helper.
package sauria_demo_pkg;

    localparam int MaxChannels = 8;

    localparam logic [7:0] RegCtrl    = 8'h00;
    localparam logic [7:0] RegStatus  = 8'h04;
    localparam logic [7:0] RegIrqEn   = 8'h08;
    localparam logic [7:0] RegIrqPend = 8'h0C;
    localparam logic [7:0] RegTimeout = 8'h10;
    localparam logic [7:0] RegErr     = 8'h14;

    typedef enum logic [1:0] {
        CH_IDLE    = 2'd0,
        CH_RUN     = 2'd1,
        CH_DONE    = 2'd2,
        CH_TIMEOUT = 2'd3
    } chan_state_e;

    typedef struct packed {
        logic [31:0] AxiExtNumSlv;
        logic [31:0] RegExtNumSlv;
    } cheshire_ext_cfg_t;

    // One AXI slave window per accelerator instance plus a single register slave for this controller.
    function automatic cheshire_ext_cfg_t sauria_cheshire_cfg(input int unsigned num_channels);
        cheshire_ext_cfg_t cfg;
        cfg.AxiExtNumSlv = 32'(num_channels);
        cfg.RegExtNumSlv = 32'd1;
        return cfg;
    endfunction

endpackage

// File: rtl/sauria_demo_chan.sv
// One accelerator channel: start/run/done/timeout sequencing with a
// saturating run-cycle counter used as the watchdog.
module sauria_demo_chan
    import sauria_demo_pkg::*;
#(
    parameter int TimeoutWidth = 24
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    start_req,
    input  logic                    done,
    input  logic                    irq_clear,
    input  logic [TimeoutWidth-1:0] timeout,
    output chan_state_e             state,
    output logic                    start_pulse,
    output logic                    set_pend,
    output logic                    collision
);

    chan_state_e             state_reg, state_next;
    logic [TimeoutWidth-1:0] count_reg, count_next;
    logic                    start_pulse_reg, start_pulse_next;
    logic [TimeoutWidth:0]   count_inc;

    // One extra bit so the all-ones counter can never alias a nonzero limit.
    assign count_inc = {1'b0, count_reg} + (TimeoutWidth + 1)'(1);

    always_comb begin
        state_next       = state_reg;
        count_next       = count_reg;
        start_pulse_next = 1'b0;
        case (state_reg)
            CH_IDLE: begin
                if (start_req) begin
                    state_next       = CH_RUN;
                    count_next       = '0;
                    start_pulse_next = 1'b1;
                end
            end
            CH_RUN: begin
                count_next = (&count_reg) ? count_reg : count_inc[TimeoutWidth-1:0];
                if (done) begin
                    state_next = CH_DONE;
                end else if ((|timeout) && (count_inc == {1'b0, timeout})) begin
                    state_next = CH_TIMEOUT;
                end
            end
            default: begin
                if (irq_clear) begin
                    state_next = CH_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg       <= CH_IDLE;
            count_reg       <= '0;
            start_pulse_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            count_reg       <= count_next;
            start_pulse_reg <= start_pulse_next;
        end
    end

    assign state       = state_reg;
    assign start_pulse = start_pulse_reg;
    assign set_pend    = (state_reg == CH_RUN) && (state_next != CH_RUN);
    assign collision   = start_req && (state_reg != CH_IDLE);

endmodule

// File: rtl/sauria_demo_ctrl.sv
// Register-mapped controller for up to eight SAURIA instances: zero-wait
// register port, per-channel start/done/timeout tracking and interrupts.
module sauria_demo_ctrl
    import sauria_demo_pkg::*;
#(
    parameter int NumChannels  = 2,
    parameter int AddrWidth    = 8,
    parameter int TimeoutWidth = 24
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   reg_req_valid_i,
    input  logic                   reg_req_write_i,
    input  logic [AddrWidth-1:0]   reg_req_addr_i,
    input  logic [31:0]            reg_req_wdata_i,
    output logic                   reg_rsp_ready_o,
    output logic [31:0]            reg_rsp_rdata_o,
    output logic                   reg_rsp_error_o,
    output logic [NumChannels-1:0] acc_start_o,
    input  logic [NumChannels-1:0] acc_done_i,
    output logic [NumChannels-1:0] irq_o,
    output logic                   irq_any_o
);

    logic sel_ctrl, sel_status, sel_irq_en, sel_pend, sel_timeout, sel_err;
    logic wr_en, wr_ctrl, wr_irq_en, wr_pend, wr_timeout, wr_err;

    assign sel_ctrl    = reg_req_addr_i == AddrWidth'(RegCtrl);
    assign sel_status  = reg_req_addr_i == AddrWidth'(RegStatus);
    assign sel_irq_en  = reg_req_addr_i == AddrWidth'(RegIrqEn);
    assign sel_pend    = reg_req_addr_i == AddrWidth'(RegIrqPend);
    assign sel_timeout = reg_req_addr_i == AddrWidth'(RegTimeout);
    assign sel_err     = reg_req_addr_i == AddrWidth'(RegErr);

    assign wr_en      = reg_req_valid_i & reg_req_write_i;
    assign wr_ctrl    = wr_en & sel_ctrl;
    assign wr_irq_en  = wr_en & sel_irq_en;
    assign wr_pend    = wr_en & sel_pend;
    assign wr_timeout = wr_en & sel_timeout;
    assign wr_err     = wr_en & sel_err;

    logic [NumChannels-1:0]  irq_en_reg, irq_pend_reg, irq_pend_next, err_reg, err_next, irq_reg;
    logic [TimeoutWidth-1:0] timeout_reg;
    logic [NumChannels-1:0]  start_req, irq_clear, start_pulse, set_pend, collision;
    chan_state_e             chan_state [NumChannels];
    logic [31:0]             status_word;
    logic                    unused_wdata;

    // Only the low bits of write data are ever stored; the rest are ignored by design.
    assign unused_wdata = ^reg_req_wdata_i;

    assign status_word[31:2*NumChannels] = '0;

    for (genvar gi = 0; gi < NumChannels; gi++) begin : g_chan
        assign start_req[gi] = wr_ctrl & reg_req_wdata_i[gi];
        assign irq_clear[gi] = wr_pend & reg_req_wdata_i[gi];

        sauria_demo_chan #(
            .TimeoutWidth(TimeoutWidth)
        ) u_chan (
            .clk        (clk_i),
            .srst       (rst_i),
            .start_req  (start_req[gi]),
            .done       (acc_done_i[gi]),
            .irq_clear  (irq_clear[gi]),
            .timeout    (timeout_reg),
            .state      (chan_state[gi]),
            .start_pulse(start_pulse[gi]),
            .set_pend   (set_pend[gi]),
            .collision  (collision[gi])
        );

        assign status_word[2*gi+1:2*gi] = chan_state[gi];
    end

    // A new event in the same cycle as a clear keeps the bit set.
    assign irq_pend_next = (irq_pend_reg & ~irq_clear) | set_pend;
    assign err_next      = (err_reg & ~({NumChannels{wr_err}} & reg_req_wdata_i[NumChannels-1:0])) | collision;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_en_reg   <= '0;
            irq_pend_reg <= '0;
            err_reg      <= '0;
            irq_reg      <= '0;
            timeout_reg  <= '0;
        end else begin
            if (wr_irq_en) begin
                irq_en_reg <= reg_req_wdata_i[NumChannels-1:0];
            end
            if (wr_timeout) begin
                timeout_reg <= reg_req_wdata_i[TimeoutWidth-1:0];
            end
            irq_pend_reg <= irq_pend_next;
            err_reg      <= err_next;
            irq_reg      <= irq_pend_reg & irq_en_reg;
        end
    end

    logic [31:0] rd_data;
    logic        rd_hit;

    always_comb begin
        rd_data         = '0;
        rd_hit          = 1'b1;
        reg_rsp_rdata_o = '0;
        reg_rsp_error_o = 1'b0;
        if (sel_ctrl) begin
            rd_data = '0;
        end else if (sel_status) begin
            rd_data = status_word;
        end else if (sel_irq_en) begin
            rd_data = 32'(irq_en_reg);
        end else if (sel_pend) begin
            rd_data = 32'(irq_pend_reg);
        end else if (sel_timeout) begin
            rd_data = 32'(timeout_reg);
        end else if (sel_err) begin
            rd_data = 32'(err_reg);
        end else begin
            rd_hit = 1'b0;
        end
        if (reg_req_valid_i) begin
            if (!rd_hit || (reg_req_write_i && sel_status)) begin
                reg_rsp_error_o = 1'b1;
            end else if (!reg_req_write_i) begin
                reg_rsp_rdata_o = rd_data;
            end
        end
    end

    assign reg_rsp_ready_o = reg_req_valid_i;
    assign acc_start_o     = start_pulse;
    assign irq_o           = irq_reg;
    assign irq_any_o       = |irq_reg;

endmodule
